median_engine: RTL
==================

MEDIAN_ENGINE -- requirements
Module: median_engine

Interface
REQ-001 Parameter WIDTH, default 8, pixel bit width (>=1).
REQ-002 Parameter N_PIXELS, default 9, window size (odd, >=3).
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 DI  in  WIDTH  input pixel.
REQ-006 IN_VALID  in  1  DI valid.
REQ-007 IN_READY  out  1  engine accepts pixel; transfer when IN_VALID & IN_READY at rising edge.
REQ-008 BYP  in  1  bypass mode request, sampled with first pixel of each window.
REQ-009 DO  out  WIDTH  result pixel.
REQ-010 OUT_VALID  out  1  DO valid.
REQ-011 OUT_READY  in  1  consumer accepts; transfer when OUT_VALID & OUT_READY at rising edge.

Function
REQ-012 The FSM SHALL have exactly three states: LOAD, SORT and OUT.
REQ-013 In LOAD: IN_READY=1, OUT_VALID=0; each transfer shifts DI into window register R[0], R[i+1]<=R[i]; the pixel counter increments.
REQ-014 No transfer when IN_VALID=0: window, counter and state SHALL hold (gaps of any length are legal).
REQ-015 Mode latch SHALL capture BYP on the transfer of pixel 0; BYP at any other time SHALL be ignored.
REQ-016 On the transfer of pixel N_PIXELS-1 with mode=sort: next state SORT, counter cleared.
REQ-017 On the transfer of pixel N_PIXELS-1 with mode=bypass: next state OUT, DO <= pixel with arrival index (N_PIXELS-1)/2; OUT_VALID high the next cycle (latency 1).
REQ-018 SORT SHALL run exactly P*N_PIXELS cycles, P=(N_PIXELS+1)/2 passes, using one compare-exchange (MAX/MIN) per cycle; IN_READY=0, OUT_VALID=0 throughout.
REQ-019 Each pass SHALL be N_PIXELS-1 exchange cycles (R[N-1]<=MAX, min recirculated to R[0], others shift) followed by 1 bypass cycle parking the pass maximum.
REQ-020 After the last SORT cycle: state OUT, DO = P-th largest value of the window (the median); OUT_VALID first high exactly P*N_PIXELS+1 cycles after the edge accepting the last pixel (46 for N=9).
REQ-021 Duplicates SHALL be handled by value: median of a multiset is its P-th largest element.
REQ-022 In OUT: OUT_VALID=1, IN_READY=0, DO stable until transfer; OUT_READY low for any number of cycles SHALL hold DO and state.
REQ-023 On output transfer: next state LOAD, counter cleared; IN_READY=1 in the following cycle (no dead cycle beyond it).
REQ-024 DO SHALL retain its last value outside OUT; it is meaningful only while OUT_VALID=1.
REQ-025 Arithmetic: comparisons unsigned, WIDTH bits, no truncation or extension of pixel values.

Reset
REQ-026 RST=1 at an edge SHALL force state LOAD, counter 0, mode 0, all R[i]=0, DO=0, OUT_VALID=0; IN_READY=1 in the first cycle after RST deasserts.
REQ-027 RST SHALL take priority over every transfer and abort LOAD, SORT or OUT mid-operation; a partial window SHALL be discarded.

Structure
REQ-028 A shared package median_pkg SHALL hold the state enum (LOAD, SORT, OUT), default WIDTH/N_PIXELS constants and a constant function computing P and counter widths.
REQ-029 Exactly one sub-module SHALL be instantiated: MCE (combinational compare-exchange, ports A, B, MAX, MIN, parameter WIDTH).
REQ-030 Counter width SHALL be $clog2(P*N_PIXELS+1); no other multiplier or sorter hardware is permitted.

Verification
REQ-031 N=9, BYP=0, DI=5,3,9,1,7,2,8,4,6 back-to-back, OUT_READY=1 -> OUT_VALID high 46 cycles after last accept, DO=5, one cycle, then IN_READY=1.
REQ-032 N=9, DI=0,0,0,0,255,255,255,255,255 -> DO=255; DI all 0x80 -> DO=0x80.
REQ-033 N=9, BYP=1 with pixel 0, same sequence as REQ-031 -> DO=7, OUT_VALID high 1 cycle after last accept.
REQ-034 REQ-031 stimulus with OUT_READY=0 for 10 cycles after OUT_VALID -> DO=5 and OUT_VALID=1 stable all 10 cycles, IN_READY=0; release -> single transfer.
REQ-035 RST pulse at SORT cycle 20 -> next cycle OUT_VALID=0, IN_READY=1, DO=0; a fresh window then gives correct median.
REQ-036 IN_VALID toggled randomly, N=3 and N=9 builds, 1000 random windows -> DO equals reference median each window, latency rule REQ-020 holds.

Source files
------------

// File: rtl/median_pkg.sv
// Shared state encoding and sizing helpers for the median engine.
package median_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_N_PIXELS = 9;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Number of max-extraction passes needed to reach the median.
  function automatic int num_passes(input int n_pixels);
    return (n_pixels + 1) / 2;
  endfunction

  function automatic int sort_cycles(input int n_pixels);
    return num_passes(n_pixels) * n_pixels;
  endfunction

  function automatic int counter_width(input int n_pixels);
    return $clog2(sort_cycles(n_pixels) + 1);
  endfunction

  function automatic int pos_width(input int n_pixels);
    return $clog2(n_pixels);
  endfunction

endpackage

// File: rtl/median_engine_mce.sv
// Combinational compare-exchange: unsigned max/min of two pixels.
module MCE
  import median_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN
);

  logic a_ge_b;

  assign a_ge_b = (A >= B);
  assign MAX    = a_ge_b ? A : B;
  assign MIN    = a_ge_b ? B : A;

endmodule

// File: rtl/median_engine.sv
// Streaming median filter: loads a window, then extracts the running maximum
// once per pass with a single compare-exchange until the median is reached.
module median_engine
  import median_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int N_PIXELS = DEFAULT_N_PIXELS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             BYP,
  output logic [WIDTH-1:0] DO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int CW      = counter_width(N_PIXELS);
  localparam int PW      = pos_width(N_PIXELS);
  // Slot holding the middle arrival just before the final pixel shifts in.
  localparam int MID_PRE = (N_PIXELS - 1) / 2 - 1;

  localparam logic [CW-1:0] LAST_PIXEL = CW'(N_PIXELS - 1);
  localparam logic [CW-1:0] LAST_SORT  = CW'(sort_cycles(N_PIXELS) - 1);
  localparam logic [PW-1:0] LAST_POS   = PW'(N_PIXELS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic [WIDTH-1:0] win_q     [N_PIXELS];
  logic [WIDTH-1:0] win_d     [N_PIXELS];
  logic [WIDTH-1:0] win_shift [N_PIXELS];
  logic [WIDTH-1:0] mce_max, mce_min;

  MCE #(.WIDTH(WIDTH)) u_mce (
    .A  (win_q[N_PIXELS-1]),
    .B  (win_q[N_PIXELS-2]),
    .MAX(mce_max),
    .MIN(mce_min)
  );

  // Plain one-slot shift; slot 0 is filled by whichever path uses it.
  assign win_shift[0] = '0;
  for (genvar gi = 1; gi < N_PIXELS; gi++) begin : g_shift
    assign win_shift[gi] = win_q[gi-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    mode_d    = mode_q;
    do_d      = do_q;
    win_d     = win_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;

    unique case (state_q)
      LOAD: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          win_d    = win_shift;
          win_d[0] = DI;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == '0) begin
            mode_d = BYP;
          end
          if (cnt_q == LAST_PIXEL) begin
            cnt_d = '0;
            pos_d = '0;
            if (mode_q) begin
              state_d = OUT;
              do_d    = win_q[MID_PRE];
            end else begin
              state_d = SORT;
            end
          end
        end
      end

      SORT: begin
        cnt_d = cnt_q + CW'(1);
        if (pos_q == LAST_POS) begin
          // Pass maximum leaves the ring; a zero takes its place so it can
          // never win a later pass.
          pos_d = '0;
          win_d = win_shift;
          if (cnt_q == LAST_SORT) begin
            do_d    = win_q[N_PIXELS-1];
            state_d = OUT;
            cnt_d   = '0;
          end
        end else begin
          pos_d              = pos_q + PW'(1);
          win_d              = win_shift;
          win_d[0]           = mce_min;
          win_d[N_PIXELS-1]  = mce_max;
        end
      end

      OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pos_q   <= '0;
      mode_q  <= 1'b0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      do_q    <= do_d;
    end
  end

  for (genvar gi = 0; gi < N_PIXELS; gi++) begin : g_win
    always_ff @(posedge CLK) begin
      if (RST) begin
        win_q[gi] <= '0;
      end else begin
        win_q[gi] <= win_d[gi];
      end
    end
  end

  assign DO = do_q;

endmodule
